// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : fetch sequencer states
//   if_payload_t  : instruction word plus its address, as handed to decode
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] PC_INC           = 32'd4;
   localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } if_payload_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register.
//   clk, rst  : clock, asynchronous active-low reset (loads RESET_VECTOR)
//   load_en   : load load_val (redirect or trap); wins over inc_en
//   inc_en    : advance by PC_INC, modulo 2^32
//   pc        : current fetch address
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic [XLEN-1:0] load_val,
   input  logic            inc_en,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;

   // Next pc: load beats increment
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end else if (inc_en) begin
         pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch pc, drives the imem
// req/gnt/rvalid port and hands one instruction at a time to decode.
// Handles stall, redirect, and squashing of an in-flight fetch.
//   clk, rst                    : clock, asynchronous active-low reset
//   stall                       : hazard stall (blocks new requests and hand-off)
//   redirect_valid/_target      : branch/jump redirect
//   imem_req/_addr/_gnt         : request channel (imem_addr is always pc)
//   imem_rvalid/_rdata          : in-order response channel
//   if_valid/_instr/_pc/_ready  : decode hand-off
//   misaligned                  : sticky misaligned-redirect flag
// Build option MISALIGN_TRAP_EN: misaligned redirect targets trap to
// TRAP_VECTOR and set misaligned; otherwise target[1:0] is forced to 0
// and the misaligned port does not exist.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready
`ifdef MISALIGN_TRAP_EN
   ,
   output logic            misaligned
`endif
);

   fetch_state_t    state_q, state_d;
   logic            kill_q, kill_d;
   logic            if_valid_q, if_valid_d;
   if_payload_t     out_q, out_d;
   logic            redir;
   logic            pc_load;
   logic            pc_inc;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] load_val;

   // Redirect target selection
`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d;
   logic tgt_mis;

   assign tgt_mis  = (redirect_target[1:0] != 2'b00);
   assign load_val = tgt_mis ? TRAP_VECTOR : redirect_target;
`else
   logic unused_bits;

   assign load_val    = {redirect_target[XLEN-1:2], 2'b00};
   assign unused_bits = ^{TRAP_VECTOR, redirect_target[1:0]};
`endif

   fetch_pc_reg #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load_en  (pc_load),
      .load_val (load_val),
      .inc_en   (pc_inc),
      .pc       (pc)
   );

   // Request is combinational on stall so a stalled REQ never issues
   assign imem_req  = (state_q == REQ) && !stall;
   assign imem_addr = pc;
   assign redir     = redirect_valid && (state_q != BOOT);

   // Next-state, kill, decode register and pc control
   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      if_valid_d = if_valid_q;
      out_d      = out_q;
      pc_load    = redir;
      pc_inc     = 1'b0;
      unique case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (imem_req && imem_gnt) begin
               // granted at the old pc while redirecting: squash that response
               kill_d  = redirect_valid;
               state_d = RESP;
            end
         end
         RESP: begin
            if (imem_rvalid) begin
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  if_valid_d = 1'b1;
                  out_d      = '{instr: imem_rdata, pc: pc};
                  pc_inc     = 1'b1;
                  state_d    = HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            // redirect flushes the held instruction even if decode is ready
            if (redirect_valid || (if_ready && !stall)) begin
               if_valid_d = 1'b0;
               state_d    = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= BOOT;
         kill_q     <= 1'b0;
         if_valid_q <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         if_valid_q <= if_valid_d;
         out_q      <= out_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Sticky until reset
   always_comb begin
      mis_d = mis_q | (redir && tgt_mis);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misaligned = mis_q;
`endif

   assign if_valid = if_valid_q;
   assign if_instr = out_q.instr;
   assign if_pc    = out_q.pc;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the single-issue core. It owns the fetch PC, drives a req/gnt/rvalid instruction-memory port, and presents one instruction at a time to decode through a valid/ready handshake. It also handles pipeline stall and branch/jump redirect, including squashing a fetch already in flight.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (used only with MISALIGN_TRAP_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  pipeline stall from hazard logic
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  32  new fetch address
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, equals pc
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid, one cycle, in order
imem_rdata  in  32  instruction word
if_valid  out  1  instruction available to decode
if_instr  out  32  instruction word
if_pc  out  32  address of if_instr
if_ready  in  1  decode accepts instruction
misaligned  out  1  sticky misaligned-redirect flag (only with MISALIGN_TRAP_EN)

Behaviour:
- Reset (rst=0, async): state=BOOT, pc=RESET_VECTOR, kill=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, misaligned=0.
- FSM states: BOOT, REQ, RESP, HOLD. imem_addr=pc at all times.
- BOOT: imem_req=0. Moves to REQ on the next edge after reset release.
- REQ: imem_req = !stall. On req&&gnt, go to RESP. The address may change while req is held and gnt is low; the memory samples the address only on the gnt cycle.
- RESP: imem_req=0. Waits for rvalid; stall is ignored here.
  - On rvalid with kill=0 and !redirect_valid: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to HOLD.
  - On rvalid with kill=1 or redirect_valid: discard the data, clear kill, go to REQ.
- HOLD: if_valid=1 and if_instr/if_pc are held stable.
  - On if_ready && !stall: if_valid<=0, go to REQ.
- Redirect has priority over every other event in every state except BOOT:
  - It always performs pc<=redirect_target.
  - In REQ, the next request uses the new pc; if gnt arrives in the same cycle, set kill<=1 and go to RESP.
  - In RESP without rvalid, set kill<=1.
  - In HOLD, if_valid<=0 on the same edge (the instruction is flushed, even if if_ready=1), then go to REQ.
  - Redirect in BOOT is ignored.
- Arithmetic: pc+4 is computed modulo 2^32 (FFFF_FFFC wraps to 0000_0000).
- Latency:
  - Redirect to imem_req at the target: 1 cycle.
  - Zero-wait memory gives 1 instruction per 3 cycles (REQ, RESP, HOLD with if_ready=1).
- Reset mid-fetch: an outstanding response is simply never captured. The memory must also reset.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a redirect with target[1:0]!=0 loads pc<=TRAP_VECTOR instead of the target and sets misaligned<=1. The flag stays set until reset. Kill and flush rules are unchanged.
- Undefined: no misaligned port; target[1:0] is forced to 2'b00.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {BOOT, REQ, RESP, HOLD}
  - localparam PC_INC=32'd4
  - default vector constants
- One sub-module, fetch_pc_reg: the pc register with async active-low reset, load (redirect/trap) and increment enables. Load has priority over increment.
- The FSM, kill flag and decode output register stay in fetch_controller.

Test Plan:
- Reset release, gnt=1 every cycle, rvalid the cycle after gnt, if_ready=1 -> imem_addr sequence 0,4,8; if_pc 0,4,8 spaced 3 cycles apart; if_instr matches memory.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stable; no imem_req asserted; the fetch at pc+4 starts 1 cycle after if_ready=1.
- redirect_valid with target 0x40 while in RESP, rvalid 2 cycles later -> response discarded, if_valid stays 0, next imem_addr=0x40.
- redirect to 0x80 in HOLD with if_ready=1 on the same cycle -> if_valid falls, the held instruction is not consumed, next imem_addr=0x80.
- pc=0xFFFF_FFFC, instruction captured -> pc wraps to 0x0000_0000, if_pc=0xFFFF_FFFC.
- With MISALIGN_TRAP_EN, redirect to 0x42 -> imem_addr=0x100, misaligned=1 and stays 1 until rst=0.
